// File: rtl/ppu_line_buf.sv
// ppu_line_buf
// Ping-pong line buffer for the VGA pixel path. One bank fills from the
// pixel source while the other drains to scan-out. Each line is emitted with
// per-line mirroring, inversion and horizontal pixel doubling.
//
// Ports:
//   clk     - single clock, all state changes on the rising edge
//   rst     - asynchronous active-low reset
//   sync    - synchronous flush pulse (frame/line resync), overrides all
//   mode    - [0] mirror, [1] invert, [2] pixel-double; sampled at line start
//   data_i  - input pixel
//   stb_i   - input pixel valid
//   ack_i   - input ready (registered decode only, no path from stb_i)
//   data_o  - output pixel (registered)
//   stb_o   - output pixel valid (registered)
//   ack_o   - downstream ready
module ppu_line_buf #(
    parameter int DATA_W   = 8,
    parameter int LINE_LEN = 32,
    parameter int IDX_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sync,
    input  logic [2:0]        mode,
    input  logic [DATA_W-1:0] data_i,
    input  logic              stb_i,
    output logic              ack_i,
    output logic [DATA_W-1:0] data_o,
    output logic              stb_o,
    input  logic              ack_o
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    localparam logic [IDX_W-1:0] LAST_WR = IDX_W'(LINE_LEN - 1);
    localparam logic [IDX_W:0]   LAST_1X = (IDX_W + 1)'(LINE_LEN - 1);
    localparam logic [IDX_W:0]   LAST_2X = (IDX_W + 1)'(2 * LINE_LEN - 1);

    logic [DATA_W-1:0] mem [2][LINE_LEN];

    logic [1:0]        full;
    logic [1:0]        full_set;
    logic [1:0]        full_clr;
    logic              wr_bank;
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_fire;

    state_t            state;
    state_t            state_nx;
    logic              rd_bank;
    logic              bank_nx;
    logic [IDX_W:0]    rd_cnt;
    logic [IDX_W:0]    cnt_nx;
    logic [IDX_W:0]    rd_last;
    logic [2:0]        lm;
    logic [2:0]        lm_nx;
    logic              stb_nx;
    logic              load;
    logic              free;

    logic [IDX_W-1:0]  pix_idx;
    logic [IDX_W-1:0]  addr;
    logic [DATA_W-1:0] pix;
    logic [DATA_W-1:0] data_nx;

    // The source may push whenever the bank it points at is empty; holding
    // ack_i low during reset keeps the source from pushing into a dead block.
    assign ack_i   = rst & ~full[wr_bank];
    assign wr_fire = stb_i & ack_i & ~sync;

    // Writer completes a line by raising its bank's full flag; the reader
    // frees its bank at the end of a line. The two never touch the same bank
    // on one edge because the writer only targets an empty bank.
    assign full_set = (wr_fire && (wr_idx == LAST_WR)) ? (2'b01 << wr_bank) : 2'b00;
    assign full_clr = free ? (2'b01 << rd_bank) : 2'b00;

    // Pixel storage; contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_bank][wr_idx] <= data_i;
        end
    end

    // Write-side bookkeeping: index within the line, current bank and the
    // per-bank full flags shared with the reader.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full    <= 2'b00;
            wr_idx  <= '0;
            wr_bank <= 1'b0;
        end else if (sync) begin
            full    <= 2'b00;
            wr_idx  <= '0;
            wr_bank <= 1'b0;
        end else begin
            full <= (full | full_set) & ~full_clr;
            if (wr_fire) begin
                if (wr_idx == LAST_WR) begin
                    wr_idx  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end
        end
    end

    assign rd_last = lm[2] ? LAST_2X : LAST_1X;

    // Read FSM next-state. Every path that presents a new pixel raises
    // 'load' and describes the pixel through cnt_nx/lm_nx/bank_nx, so the
    // fetch below always looks at the values that will be in force after
    // this edge. That is what lets a new line start with no bubble.
    always_comb begin
        state_nx = state;
        bank_nx  = rd_bank;
        cnt_nx   = rd_cnt;
        lm_nx    = lm;
        stb_nx   = stb_o;
        load     = 1'b0;
        free     = 1'b0;
        unique case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    state_nx = SEND;
                    lm_nx    = mode;
                    cnt_nx   = '0;
                    stb_nx   = 1'b1;
                    load     = 1'b1;
                end
            end
            SEND: begin
                if (ack_o) begin
                    if (rd_cnt != rd_last) begin
                        cnt_nx = rd_cnt + 1'b1;
                        load   = 1'b1;
                    end else begin
                        free    = 1'b1;
                        bank_nx = ~rd_bank;
                        if (full[~rd_bank]) begin
                            lm_nx  = mode;
                            cnt_nx = '0;
                            load   = 1'b1;
                        end else begin
                            state_nx = IDLE;
                            stb_nx   = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                stb_nx   = 1'b0;
            end
        endcase
        if (sync) begin
            state_nx = IDLE;
            bank_nx  = 1'b0;
            stb_nx   = 1'b0;
            load     = 1'b0;
            free     = 1'b0;
        end
    end

    // Pixel fetch: doubling halves the beat count, mirroring reverses the
    // address, inversion flips the data.
    always_comb begin
        pix_idx = lm_nx[2] ? cnt_nx[IDX_W:1] : cnt_nx[IDX_W-1:0];
        addr    = lm_nx[0] ? (LAST_WR - pix_idx) : pix_idx;
        pix     = mem[bank_nx][addr];
        data_nx = lm_nx[1] ? ~pix : pix;
    end

    // Read-side registers. data_o only changes when a new pixel is
    // presented, so it is stable while stalled and holds across sync.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            rd_bank <= 1'b0;
            rd_cnt  <= '0;
            lm      <= 3'b000;
            stb_o   <= 1'b0;
            data_o  <= '0;
        end else begin
            state   <= state_nx;
            rd_bank <= bank_nx;
            rd_cnt  <= cnt_nx;
            lm      <= lm_nx;
            stb_o   <= stb_nx;
            if (load) begin
                data_o <= data_nx;
            end
        end
    end

endmodule
